rv_instr_encoder: RTL and testbench

//  RV32I instruction encoder, the inverse of the instruction decoder. Takes instruction fields

---
 rtl/rv_instr_encoder.sv | 156 +++++++++++++++
 tb/tb_rv_instr_encoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: packs field tuples into 32-bit words by format,
// rejects out-of-range immediates, and tags each word with a running byte address.
module rv_instr_encoder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_load_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_sticky,
  output logic [7:0]            err_count,
  output logic [15:0]           word_count
);

  localparam int unsigned IW  = 32;
  localparam int unsigned ECW = 8;
  localparam int unsigned WCW = 16;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic                  out_valid_q, out_valid_d;
  logic [IW-1:0]         out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [ECW-1:0]        err_count_q, err_count_d;
  logic [WCW-1:0]        word_count_q, word_count_d;

  logic          fits_12, fits_13, fits_21;
  logic          enc_legal;
  logic [IW-1:0] enc_instr;
  logic          accept;

  // Field packing and immediate range check; a range fits when all upper bits equal the sign.
  always_comb begin
    fits_12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    fits_13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    fits_21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    enc_legal = 1'b0;
    enc_instr = '0;
    case (in_fmt)
      FMT_R: begin
        enc_legal = 1'b1;
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        enc_legal = fits_12;
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        enc_legal = fits_12;
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        enc_legal = fits_13 & ~in_imm[0];
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        enc_legal = ~(|in_imm[11:0]);
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
      end
      FMT_J: begin
        enc_legal = fits_21 & ~in_imm[0];
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: begin
        enc_legal = 1'b0;
        enc_instr = '0;
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register, address counter and error/word bookkeeping.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    addr_cnt_d   = addr_cnt_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && enc_legal) begin
      out_valid_d  = 1'b1;
      out_instr_d  = enc_instr;
      out_addr_d   = addr_cnt_q;
      addr_cnt_d   = addr_cnt_q + ADDR_WIDTH'(4);
      word_count_d = word_count_q + WCW'(1);
    end
    if (accept && !enc_legal) begin
      err_sticky_d = 1'b1;
      if (err_count_q != {ECW{1'b1}}) begin
        err_count_d = err_count_q + ECW'(1);
      end
    end
    // A load overrides the increment; the word above already took the old value.
    if (addr_load) begin
      addr_cnt_d = addr_load_value & ~ADDR_WIDTH'(3);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      addr_cnt_q   <= BASE_ADDR;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      addr_cnt_q   <= addr_cnt_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: spec-level scoreboard checked every cycle, plus
// hand-computed encodings and addresses for directed vectors.
module tb_rv_instr_encoder;

  localparam int unsigned AW = 32;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          addr_load;
  logic [AW-1:0] addr_load_value;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err_sticky;
  logic [7:0]    err_count;
  logic [15:0]   word_count;

  rv_instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .addr_load_value(addr_load_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_sticky(err_sticky), .err_count(err_count),
    .word_count(word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {longint instr; longint addr;} word_t;
  typedef struct {longint instr; longint addr; int cyc;} log_t;
  word_t exp_q[$];
  log_t  log_q[$];

  longint m_cnt;
  int     m_err, m_words, cyc;
  bit     m_sticky;
  bit     m_ok = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level encoder: bit fields picked out arithmetically from the signed offset.
  function automatic bit model_enc(input int fmt, input longint op, input longint rd,
                                   input longint rs1, input longint rs2, input longint f3,
                                   input longint f7, input logic [31:0] imm_raw,
                                   output longint instr);
    longint imm;
    bit legal;
    imm   = longint'($signed(imm_raw));
    legal = 1'b0;
    instr = 0;
    case (fmt)
      0: begin
        legal = 1'b1;
        instr = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
      end
      1: begin
        legal = (imm >= -2048) && (imm <= 2047);
        instr = ((imm & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
      end
      2: begin
        legal = (imm >= -2048) && (imm <= 2047);
        instr = (((imm >> 5) & 'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
              + ((imm & 'h1F) << 7) + op;
      end
      3: begin
        legal = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
        instr = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + (rs2 << 20)
              + (rs1 << 15) + (f3 << 12) + (((imm >> 1) & 15) << 8)
              + (((imm >> 11) & 1) << 7) + op;
      end
      4: begin
        legal = (longint'(imm_raw) % 4096) == 0;
        instr = (longint'(imm_raw) & 'hFFFFF000) + (rd << 7) + op;
      end
      5: begin
        legal = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
        instr = (((imm >> 20) & 1) << 31) + (((imm >> 1) & 1023) << 21)
              + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 255) << 12) + (rd << 7) + op;
      end
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Compare against the model, then advance the model across the coming edge.
  always @(negedge clock) begin
    bit     rdy, drain, acc, legal;
    longint enc;
    word_t  w;
    cyc++;
    if (m_ok) begin
      chk("out_valid", longint'(out_valid), longint'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_instr", longint'(out_instr), exp_q[0].instr);
        chk("out_addr", longint'(out_addr), exp_q[0].addr);
      end
      chk("in_ready", longint'(in_ready), longint'(exp_q.size() == 0 || out_ready));
      chk("err_sticky", longint'(err_sticky), longint'(m_sticky));
      chk("err_count", longint'(err_count), longint'(m_err));
      chk("word_count", longint'(word_count), longint'(m_words));
    end
    if (out_valid === 1'b1 && out_ready && !reset)
      log_q.push_back('{instr: longint'(out_instr), addr: longint'(out_addr), cyc: cyc});
    if (reset) begin
      exp_q.delete();
      m_cnt = 0; m_err = 0; m_words = 0; m_sticky = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      rdy   = (exp_q.size() == 0) || out_ready;
      drain = (exp_q.size() != 0) && out_ready;
      acc   = in_valid && rdy;
      if (drain) void'(exp_q.pop_front());
      if (acc) begin
        legal = model_enc(int'(in_fmt), longint'(in_opcode), longint'(in_rd), longint'(in_rs1),
                          longint'(in_rs2), longint'(in_funct3), longint'(in_funct7),
                          in_imm, enc);
        if (legal) begin
          w.instr = enc & 'hFFFFFFFF;
          w.addr  = m_cnt;
          exp_q.push_back(w);
          m_cnt   = (m_cnt + 4) % 64'h1_0000_0000;
          m_words = (m_words + 1) % 65536;
        end else begin
          m_sticky = 1'b1;
          if (m_err < 255) m_err++;
        end
      end
      if (addr_load) m_cnt = longint'(addr_load_value) & 'hFFFFFFFC;
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // Called and returns one time unit after a rising edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int n;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        total++; bad++;
        $display("FAIL send_timeout: got in_ready=0 want 1 within 20 cycles");
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input longint instr, input longint addr);
    @(negedge clock);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_instr"}, longint'(out_instr), instr);
    chk({name, "_addr"}, longint'(out_addr), addr);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input longint instr,
                         input longint addr);
    total++;
    if (idx >= log_q.size()) begin
      bad++;
      $display("FAIL %s: got %0d words want more than %0d", name, log_q.size(), idx);
    end else begin
      total--;
      chk({name, "_instr"}, log_q[idx].instr, instr);
      chk({name, "_addr"}, log_q[idx].addr, addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0;
    addr_load_value = '0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_instr", longint'(out_instr), 0);
    chk("rst_out_addr", longint'(out_addr), 0);
    chk("rst_err_count", longint'(err_count), 0);
    @(posedge clock); #1;

    // Single I-type word, one cycle latency
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    expect_out("t1", 'h00500093, 0);

    // Back-to-back R-type pair
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    // S, B, J
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    idle(2);
    chk_log("t1_log", 0, 'h00500093, 0);
    chk_log("t2_r0", 1, 'h002081B3, 4);
    chk_log("t2_r1", 2, 'h402081B3, 8);
    if (log_q.size() > 2) chk("t2_no_bubble", log_q[2].cyc, log_q[1].cyc + 1);
    chk_log("t3_s", 3, 'h0020A423, 12);
    chk_log("t3_b", 4, 'h00208463, 16);
    chk_log("t3_j", 5, 'h001000EF, 20);

    // Backpressure: first word held, second offered and stalled
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t4_in_ready", longint'(in_ready), 0);
      chk("t4_hold_instr", longint'(out_instr), 'h00100113);
      chk("t4_hold_addr", longint'(out_addr), 24);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    idle(2);
    chk_log("t4_a", 6, 'h00100113, 24);
    chk_log("t4_b", 7, 'h00200193, 28);
    chk("t4_count", log_q.size(), 8);

    // Rejected tuples: I out of range, odd B offset, illegal format
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(2);
    chk("t5_err_count", longint'(err_count), 3);
    chk("t5_err_sticky", longint'(err_sticky), 1);
    chk("t5_no_words", log_q.size(), 8);
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(2);
    chk_log("t5_next", 8, 'h00000013, 32);

    // Address load alongside a legal accept, then boundary immediates
    addr_load = 1'b1; addr_load_value = 32'h103;
    send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    addr_load = 1'b0;
    send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0FFE);
    idle(2);
    chk_log("t6_load", 9, 'h00300213, 36);
    chk_log("t6_after", 10, 'hFFF00293, 'h100);
    chk_log("t6_u", 11, 'h123450B7, 'h104);
    chk_log("t6_i_min", 12, 'h80000013, 'h108);
    chk_log("t6_j_min", 13, 'h8000006F, 'h10C);
    chk_log("t6_b_max", 14, 'h7E000FE3, 'h110);
    chk("t6_err_count", longint'(err_count), 4);
    chk("t6_word_count", longint'(word_count), 15);

    // Reset while a word is held
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    chk("t6_rst_valid", longint'(out_valid), 0);
    chk("t6_rst_err", longint'(err_count), 0);
    chk("t6_rst_words", longint'(word_count), 0);
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    expect_out("t6_post_rst", 'h00700393, 0);
    idle(2);
    chk("t6_total_words", log_q.size(), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
